// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux and presents the muxed beat
// to one consumer over valid/ready. Define ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
module mux4_rr_arbiter #(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic              ready,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] y,
    output logic              y_valid,
    output logic              busy
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [CW-1:0]   burst_cnt;
    logic [1:0]      nxt_idx;
    logic [1:0]      cand;
    logic            nxt_any;
    logic            xfer;
    logic            release_now;

`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]      last;
    logic [1:0]      base;

    // In GRANT the pointer about to be written is sel, so scan from it directly.
    assign base = (state == GRANT) ? sel : last;

    always_comb begin
        nxt_idx = '0;
        cand    = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = base + 2'(k);
            if (req[cand]) nxt_idx = cand;
        end
    end
`else
    always_comb begin
        nxt_idx = '0;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = 2'(k);
            if (req[cand]) nxt_idx = cand;
        end
    end
`endif

    assign nxt_any = |req;

    always_comb begin
        y = i0;
        case (sel)
            2'd0: y = i0;
            2'd1: y = i1;
            2'd2: y = i2;
            2'd3: y = i3;
            default: y = i0;
        endcase
    end

    assign y_valid     = (|gnt) & req[sel];
    assign xfer        = y_valid & ready;
    assign release_now = (state == GRANT) &&
                         (!req[sel] || (xfer && burst_cnt == CW'(MAX_BURST - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last      <= 2'd3;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (nxt_any) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << nxt_idx;
                        sel       <= nxt_idx;
                        busy      <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
`ifndef ARB_FIXED_PRIO_EN
                        last <= sel;
`endif
                        burst_cnt <= '0;
                        if (nxt_any) begin
                            gnt <= 4'b0001 << nxt_idx;
                            sel <= nxt_idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            sel   <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    sel   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
